// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl: LFSR stimulus, MISR compaction and run sequencing for the c17 self-test.
module c17_bist_ctrl #(
  parameter logic [4:0] SEED      = 5'b00001,
  parameter int         PATTERNS  = 31,
  parameter logic [7:0] MISR_POLY = 8'h1D,
  parameter logic [7:0] GOLDEN    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [4:0] cut_in,
  input  logic [1:0] cut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [4:0] pat_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [4:0] SEED_I = (SEED == 5'b0) ? 5'b00001 : SEED;
  localparam logic [4:0] LAST   = 5'(PATTERNS - 1);
  if (PATTERNS < 1 || PATTERNS > 31) begin : g_bad_patterns
    $error("c17_bist_ctrl: PATTERNS must be within 1..31");
  end
  state_t     r_state;
  logic [4:0] r_lfsr, r_cnt;
  logic [7:0] r_misr;
  logic       r_busy, r_done, r_pass;
  logic [4:0] w_lfsr_n;
  logic [7:0] w_misr_n;
  assign w_lfsr_n  = {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
  assign w_misr_n  = {r_misr[6:0], 1'b0} ^ (r_misr[7] ? MISR_POLY : 8'h00) ^ {6'b0, cut_out};
  assign cut_in    = r_lfsr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_misr;
  assign pat_cnt   = r_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_lfsr  <= SEED_I;
      r_misr  <= 8'h00;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state <= RUN;
          r_lfsr  <= SEED_I;
          r_misr  <= 8'h00;
          r_cnt   <= 5'd0;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
        RUN: begin
          r_misr <= w_misr_n;
          r_lfsr <= w_lfsr_n;
          r_cnt  <= r_cnt + 5'd1;
          // the final vector's response is folded on this same edge, so judge misr_n
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_misr_n == GOLDEN);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
